spi_slave_rx: RTL
=================

# spi_slave_rx

SPI mode-0 slave front end for the Shrike Lite FPGA fabric. It synchronises the external SCLK, CS_N and MOSI pins into the 50 MHz `clk` domain and assembles MSB-first bytes. Each completed byte is presented on `r_spi_s_rx_data` together with a one-cycle `o_spi_s_rx_done` strobe; the LED blink-rate stage consumes this pair directly. As a compile-time option, the block also shifts a reply byte out on MISO.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on SCLK/CS_N/MOSI; legal range 2–3.
- `clk`  in  1  fabric clock, 50 MHz
- `rst`  in  1  synchronous, active-high reset
- `clk_en`  out  1  clock-input enable pin; constant 1
- `spi_sclk`  in  1  SPI clock from master; idle low (mode 0)
- `spi_cs_n`  in  1  chip select, active low
- `spi_mosi`  in  1  master-out data
- `spi_miso`  out  1  slave-out data
- `spi_miso_en`  out  1  MISO output enable
- `i_spi_s_tx_data`  in  8  reply byte; sampled at each load point
- `r_spi_s_rx_data`  out  8  last completed byte; held until the next byte completes
- `o_spi_s_rx_done`  out  1  one-cycle strobe; byte valid on `r_spi_s_rx_data`
- `o_spi_s_frame_err`  out  1  one-cycle strobe; CS_N rose with a partial byte pending
- `o_spi_s_busy`  out  1  high while in SHIFT

## Operation
- Synchronisers:
  - SCLK, CS_N and MOSI each pass through `SYNC_STAGES` flops, followed by one history flop used for edge detection.
  - On reset, the CS_N chain loads 1 and the SCLK and MOSI chains load 0.
- States:
  - **WAIT_IDLE** (reset state): wait until synchronised CS_N = 1, then go to IDLE.
    - Consequence: if reset is released with CS_N low, the rest of that frame is ignored.
  - **IDLE**: on the CS_N falling edge, clear the bit counter (3 bits) and go to SHIFT.
  - **SHIFT**:
    - On each SCLK rising edge: shift register ← {shift[6:0], mosi_sync}; increment the bit counter.
    - When the counter wraps 7→0: `r_spi_s_rx_data` ← {shift[6:0], mosi_sync}; pulse `o_spi_s_rx_done`.
    - Bytes repeat back-to-back within one CS frame without limit.
    - On the CS_N rising edge: go to IDLE. If the bit counter ≠ 0, pulse `o_spi_s_frame_err` and discard the partial byte.
- Simultaneous events:
  - If the 8th SCLK rising edge and the CS_N rising edge are detected in the same `clk` cycle, the byte completes first.
  - `o_spi_s_rx_done` pulses and `o_spi_s_frame_err` does not.
- Any SCLK edge detected outside SHIFT is ignored.
- `o_spi_s_busy` = (state == SHIFT).

## Timing
- Reset values:
  - `r_spi_s_rx_data` = 0x00
  - `o_spi_s_rx_done`, `o_spi_s_frame_err`, `o_spi_s_busy` = 0
  - `spi_miso` = 0, `spi_miso_en` = 0
  - state = WAIT_IDLE
  - `clk_en` = 1 at all times
- Latency:
  - Count the first `clk` edge that samples the 8th SCLK rising edge high as edge 1.
  - `o_spi_s_rx_done` and the new `r_spi_s_rx_data` are visible after edge `SYNC_STAGES`+1, i.e. edge 3 at the default depth.
  - CS_N to `o_spi_s_frame_err` has the same latency.
- `o_spi_s_rx_done` is high for exactly one `clk` cycle per byte, and is never high in two consecutive cycles.
- SCLK constraints:
  - Each SCLK high and low phase must last at least 4 `clk` cycles, so SCLK ≤ 6.25 MHz.
  - Glitches shorter than 1 `clk` cycle may be missed; this is acceptable.
- CS_N setup: CS_N must fall at least 4 `clk` cycles before the first SCLK rising edge.
- A `rst` assertion in any state wins over all other events in that cycle.

## Configuration
- Macro: `SPI_S_TX_EN`.
- Defined:
  - A TX shift register loads `i_spi_s_tx_data` on the CS_N falling edge and again at every byte wrap.
  - `spi_miso` drives tx[7] immediately after each load.
  - On each SCLK falling edge in SHIFT, the register shifts left by one.
  - `spi_miso_en` = `o_spi_s_busy`.
  - MISO updates `SYNC_STAGES`+1 cycles after SCLK falls. This is within half an SCLK period, so mode-0 timing holds.
- Undefined:
  - No TX logic is built.
  - `spi_miso` = 0 and `spi_miso_en` = 0 constantly.
  - `i_spi_s_tx_data` is unused.

## Test plan
- **Reset:** assert `rst` for 3 cycles with arbitrary pin activity → all outputs at their reset values; `o_spi_s_busy` = 0.
- **Single byte:** CS low, send 0xA5 with SCLK = clk/8, CS high → exactly one `o_spi_s_rx_done` pulse, 3 cycles after the 8th SCLK rise; `r_spi_s_rx_data` = 0xA5 and holds after CS rises; no `o_spi_s_frame_err`.
- **Two bytes, one frame:** 0x3C then 0xC3 in one CS frame → two done pulses; data reads 0x3C, then 0xC3.
- **Aborted byte:** CS rises after 5 bits, then a new frame sends 0x81 → one `o_spi_s_frame_err` pulse and no done for the partial byte; the next frame gives done with 0x81.
- **Reset mid-frame:** assert `rst` after 4 bits with CS held low, then send 12 more bits → no done; after CS toggles high then low, 0x7E is received correctly.
- **TX reply:** `i_spi_s_tx_data` = 0x5A while the master sends 0x00.
  - With `SPI_S_TX_EN`: the master captures 0x5A on MISO, and `spi_miso_en` is high only while busy.
  - Without it: MISO = 0 and `spi_miso_en` = 0 throughout.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: synchronises SCLK/CS_N/MOSI into clk and assembles MSB-first bytes.
// Optional MISO reply shifter is built when the macro SPI_S_TX_EN is defined.
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       clk_en,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_en,
    input  logic [7:0] i_spi_s_tx_data,
    output logic [7:0] r_spi_s_rx_data,
    output logic       o_spi_s_rx_done,
    output logic       o_spi_s_frame_err,
    output logic       o_spi_s_busy
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync_chain;
    logic                   sclk_hist;
    logic                   cs_hist;
    logic                   sync_primed;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_sync;
    logic       sclk_rise;
    logic       cs_fall;
    logic       cs_rise;

    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_after;
    logic [7:0] shift_reg;
    logic       shift_active;
    logic       byte_wrap;
    logic       frame_abort;

    assign clk_en = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync       <= '0;
            cs_sync         <= '1;
            mosi_sync_chain <= '0;
            sclk_hist       <= 1'b0;
            cs_hist         <= 1'b1;
            sync_primed     <= 1'b0;
        end else begin
            sclk_sync       <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync         <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_chain <= {mosi_sync_chain[SYNC_STAGES-2:0], spi_mosi};
            sclk_hist       <= sclk_s;
            cs_hist         <= cs_s;
            sync_primed     <= 1'b1;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_sync = mosi_sync_chain[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign cs_fall   = ~cs_s & cs_hist;
    assign cs_rise   = cs_s & ~cs_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The CS_N chain resets to 1, so WAIT_IDLE only trusts it once every
    // stage has been refilled from the pin; otherwise a frame already in
    // progress at reset release would look like a fresh CS_N fall.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_IDLE: if (sync_primed && (&cs_sync)) state_next = IDLE;
            IDLE:      if (cs_fall) state_next = SHIFT;
            SHIFT:     if (cs_rise) state_next = IDLE;
            default:   state_next = WAIT_IDLE;
        endcase
    end

    assign o_spi_s_busy  = (state == SHIFT);
    assign shift_active  = o_spi_s_busy & sclk_rise;
    assign bit_cnt_after = shift_active ? (bit_cnt + 3'd1) : bit_cnt;
    assign byte_wrap     = shift_active && (bit_cnt == 3'd7);
    // A byte completing in the same cycle as CS_N rising leaves the counter at 0.
    assign frame_abort   = o_spi_s_busy && cs_rise && (bit_cnt_after != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt           <= 3'd0;
            shift_reg         <= 8'h00;
            r_spi_s_rx_data   <= 8'h00;
            o_spi_s_rx_done   <= 1'b0;
            o_spi_s_frame_err <= 1'b0;
        end else begin
            o_spi_s_rx_done   <= byte_wrap;
            o_spi_s_frame_err <= frame_abort;
            if ((state == IDLE) && cs_fall) begin
                bit_cnt <= 3'd0;
            end else if (shift_active) begin
                shift_reg <= {shift_reg[6:0], mosi_sync};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (byte_wrap) begin
                r_spi_s_rx_data <= {shift_reg[6:0], mosi_sync};
            end
        end
    end

`ifdef SPI_S_TX_EN
    logic [7:0] tx_reg;
    logic       tx_skip;
    logic       sclk_fall;

    assign sclk_fall = ~sclk_s & sclk_hist;

    // The falling edge right after a wrap reload must not shift, or bit 7
    // of the next reply byte would be lost before the master samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg  <= 8'h00;
            tx_skip <= 1'b0;
        end else if ((state == IDLE) && cs_fall) begin
            tx_reg  <= i_spi_s_tx_data;
            tx_skip <= 1'b0;
        end else if (byte_wrap) begin
            tx_reg  <= i_spi_s_tx_data;
            tx_skip <= 1'b1;
        end else if (o_spi_s_busy && sclk_fall) begin
            if (!tx_skip) begin
                tx_reg <= {tx_reg[6:0], 1'b0};
            end
            tx_skip <= 1'b0;
        end
    end

    assign spi_miso    = tx_reg[7];
    assign spi_miso_en = o_spi_s_busy;
`else
    logic unused_tx_data;

    assign unused_tx_data = ^i_spi_s_tx_data;
    assign spi_miso       = 1'b0;
    assign spi_miso_en    = 1'b0;
`endif

endmodule
